// File: rtl/execute_stage.sv
// RV32 EX stage: forwarding muxes, ALU, branch compare, PC+imm, iterative MUL, EX/MEM register.
// Latency: 1 cycle for ALU/branch/jump ops; MUL result loads MUL_N+2 edges after issue.
// Backpressure: stall_out holds the front end while a MUL runs; flush_in squashes EX and aborts MUL.
module execute_stage #(
   parameter int MUL_BITS = 1   // multiplier bits retired per BUSY cycle: 1, 2, 4 or 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        flush_in,
   input  logic        Ctl_ALUSrc_in,
   input  logic [1:0]  Ctl_ALUOp_in,
   input  logic        Ctl_MemtoReg_in,
   input  logic        Ctl_RegWrite_in,
   input  logic        Ctl_MemRead_in,
   input  logic        Ctl_MemWrite_in,
   input  logic        Ctl_Branch_in,
   input  logic        jal_in,
   input  logic        jalr_in,
   input  logic [4:0]  Rd_in,
   input  logic [6:0]  funct7_in,
   input  logic [2:0]  funct3_in,
   input  logic [31:0] PC_in,
   input  logic [31:0] Rs1_data_in,
   input  logic [31:0] Rs2_data_in,
   input  logic [31:0] Imm_in,
   input  logic [1:0]  ForwardA_in,
   input  logic [1:0]  ForwardB_in,
   input  logic [31:0] WB_data_in,
   output logic        stall_out,
   output logic        Ctl_MemtoReg_out,
   output logic        Ctl_RegWrite_out,
   output logic        Ctl_MemRead_out,
   output logic        Ctl_MemWrite_out,
   output logic        Ctl_Branch_out,
   output logic        jal_out,
   output logic        jalr_out,
   output logic        Zero_out,
   output logic [4:0]  Rd_out,
   output logic [6:0]  funct7_out,
   output logic [2:0]  funct3_out,
   output logic [31:0] ALUresult_out,
   output logic [31:0] Write_Data_out,
   output logic [31:0] PCimm_out,
   output logic [31:0] PC_out
);

   localparam int         MUL_N    = 32 / MUL_BITS;
   localparam logic [5:0] CNT_LAST = 6'(MUL_N - 1);

   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

   // Full EX/MEM payload; an all-zero value is a bubble.
   typedef struct packed {
      logic        memtoreg;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        zero;
      logic [4:0]  rd;
      logic [6:0]  funct7;
      logic [2:0]  funct3;
      logic [31:0] alu_result;
      logic [31:0] write_data;
      logic [31:0] pcimm;
      logic [31:0] pc;
   } exmem_t;

   state_t        state_q, state_d;
   exmem_t        exmem_q, exmem_d;
   logic [31:0]   mcand_q, mcand_d;
   logic [31:0]   mplier_q, mplier_d;
   logic [31:0]   acc_q, acc_d;
   logic [5:0]    cnt_q, cnt_d;

   logic [31:0]        op_a, fwd_b, op_b, alu_res, pp;
   logic signed [31:0] sra_res;
   logic [4:0]         shamt;
   logic               lt_s, lt_u, zero_c, is_mul, stall_c;
   exmem_t             alu_pkt;

   // Operand forwarding; code 11 falls back to the register file value.
   always_comb begin
      case (ForwardA_in)
         2'b10:   op_a = ALUresult_out;
         2'b01:   op_a = WB_data_in;
         default: op_a = Rs1_data_in;
      endcase
      case (ForwardB_in)
         2'b10:   fwd_b = ALUresult_out;
         2'b01:   fwd_b = WB_data_in;
         default: fwd_b = Rs2_data_in;
      endcase
      op_b = Ctl_ALUSrc_in ? Imm_in : fwd_b;
   end

   assign shamt   = op_b[4:0];
   assign sra_res = $signed(op_a) >>> shamt;
   assign lt_s    = $signed(op_a) < $signed(op_b);
   assign lt_u    = op_a < op_b;
   assign is_mul  = (Ctl_ALUOp_in == 2'b10) && (funct7_in == 7'b0000001) && (funct3_in == 3'b000);

   // ALU result; jalr target takes precedence over the ALUOp decode.
   always_comb begin
      alu_res = '0;
      if (jalr_in) begin
         alu_res = (op_a + Imm_in) & ~32'd1;
      end else begin
         case (Ctl_ALUOp_in)
            2'b00: alu_res = op_a + op_b;
            2'b01: alu_res = op_a - op_b;
            default: begin
               if (Ctl_ALUOp_in == 2'b10 && funct7_in == 7'b0000001) begin
                  // M-extension encodings other than MUL itself execute as ADD
                  alu_res = op_a + op_b;
               end else begin
                  case (funct3_in)
                     3'b000:  alu_res = (funct7_in[5] && Ctl_ALUOp_in == 2'b10) ? op_a - op_b : op_a + op_b;
                     3'b001:  alu_res = op_a << shamt;
                     3'b010:  alu_res = {31'd0, lt_s};
                     3'b011:  alu_res = {31'd0, lt_u};
                     3'b100:  alu_res = op_a ^ op_b;
                     3'b101:  alu_res = funct7_in[5] ? 32'(sra_res) : (op_a >> shamt);
                     3'b110:  alu_res = op_a | op_b;
                     default: alu_res = op_a & op_b;
                  endcase
               end
            end
         endcase
      end
   end

   // Branch condition; jumps are always taken.
   always_comb begin
      zero_c = 1'b0;
      if (Ctl_ALUOp_in == 2'b01) begin
         case (funct3_in)
            3'b000:  zero_c = (op_a == op_b);
            3'b001:  zero_c = (op_a != op_b);
            3'b100:  zero_c = lt_s;
            3'b101:  zero_c = !lt_s;
            3'b110:  zero_c = lt_u;
            3'b111:  zero_c = !lt_u;
            default: zero_c = 1'b0;
         endcase
      end
      if (jal_in || jalr_in) zero_c = 1'b1;
   end

   // Assemble the normal-cycle EX/MEM payload.
   always_comb begin
      alu_pkt            = '0;
      alu_pkt.memtoreg   = Ctl_MemtoReg_in;
      alu_pkt.regwrite   = Ctl_RegWrite_in;
      alu_pkt.memread    = Ctl_MemRead_in;
      alu_pkt.memwrite   = Ctl_MemWrite_in;
      alu_pkt.branch     = Ctl_Branch_in;
      alu_pkt.jal        = jal_in;
      alu_pkt.jalr       = jalr_in;
      alu_pkt.zero       = zero_c;
      alu_pkt.rd         = Rd_in;
      alu_pkt.funct7     = funct7_in;
      alu_pkt.funct3     = funct3_in;
      alu_pkt.alu_result = alu_res;
      alu_pkt.write_data = fwd_b;
      alu_pkt.pcimm      = PC_in + Imm_in;
      alu_pkt.pc         = PC_in;
   end

   // Sum of the MUL_BITS partial products retired this BUSY cycle.
   always_comb begin
      pp = '0;
      for (int i = 0; i < MUL_BITS; i++) begin
         if (mplier_q[i]) pp = pp + (mcand_q << i);
      end
   end

   // MUL sequencer and EX/MEM next-value selection; flush overrides everything.
   always_comb begin
      state_d  = state_q;
      exmem_d  = alu_pkt;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      stall_c  = 1'b0;
      if (flush_in) begin
         exmem_d = '0;
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (is_mul) begin
                  stall_c  = 1'b1;
                  mcand_d  = op_a;
                  mplier_d = op_b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  exmem_d  = '0;
                  state_d  = BUSY;
               end
            end
            BUSY: begin
               stall_c  = 1'b1;
               acc_d    = acc_q + pp;
               mcand_d  = mcand_q << MUL_BITS;
               mplier_d = mplier_q >> MUL_BITS;
               cnt_d    = cnt_q + 6'd1;
               exmem_d  = '0;
               if (cnt_q == CNT_LAST) state_d = DONE;
            end
            DONE: begin
               // the MUL is still held in ID/EX, so its control and Rd are current
               exmem_d.alu_result = acc_q;
               state_d            = IDLE;
            end
            default: begin
               exmem_d = '0;
               state_d = IDLE;
            end
         endcase
      end
   end

   // stall must drop as soon as reset is raised, even with a MUL sitting in ID/EX.
   assign stall_out = stall_c & ~reset;

   // State and EX/MEM pipeline register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         exmem_q  <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         exmem_q  <= exmem_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

   assign Ctl_MemtoReg_out = exmem_q.memtoreg;
   assign Ctl_RegWrite_out = exmem_q.regwrite;
   assign Ctl_MemRead_out  = exmem_q.memread;
   assign Ctl_MemWrite_out = exmem_q.memwrite;
   assign Ctl_Branch_out   = exmem_q.branch;
   assign jal_out          = exmem_q.jal;
   assign jalr_out         = exmem_q.jalr;
   assign Zero_out         = exmem_q.zero;
   assign Rd_out           = exmem_q.rd;
   assign funct7_out       = exmem_q.funct7;
   assign funct3_out       = exmem_q.funct3;
   assign ALUresult_out    = exmem_q.alu_result;
   assign Write_Data_out   = exmem_q.write_data;
   assign PCimm_out        = exmem_q.pcimm;
   assign PC_out           = exmem_q.pc;

endmodule

// File: tb/tb_execute_stage.sv
// Testbench for execute_stage: directed cases plus randomized ALU traffic against a reference model.
// Latency: expects 1-cycle EX/MEM results and MUL results 34 edges after issue (MUL_BITS=1).
// Backpressure: drives stall-aware MUL sequences, flush_in aborts and an asynchronous reset mid-MUL.
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_in;
   logic        Ctl_ALUSrc_in;
   logic [1:0]  Ctl_ALUOp_in;
   logic        Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in, Ctl_Branch_in;
   logic        jal_in, jalr_in;
   logic [4:0]  Rd_in;
   logic [6:0]  funct7_in;
   logic [2:0]  funct3_in;
   logic [31:0] PC_in, Rs1_data_in, Rs2_data_in, Imm_in;
   logic [1:0]  ForwardA_in, ForwardB_in;
   logic [31:0] WB_data_in;
   logic        stall_out;
   logic        Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out, Ctl_Branch_out;
   logic        jal_out, jalr_out, Zero_out;
   logic [4:0]  Rd_out;
   logic [6:0]  funct7_out;
   logic [2:0]  funct3_out;
   logic [31:0] ALUresult_out, Write_Data_out, PCimm_out, PC_out;

   execute_stage #(.MUL_BITS(1)) dut (
      .clk(clk), .reset(reset), .flush_in(flush_in),
      .Ctl_ALUSrc_in(Ctl_ALUSrc_in), .Ctl_ALUOp_in(Ctl_ALUOp_in),
      .Ctl_MemtoReg_in(Ctl_MemtoReg_in), .Ctl_RegWrite_in(Ctl_RegWrite_in),
      .Ctl_MemRead_in(Ctl_MemRead_in), .Ctl_MemWrite_in(Ctl_MemWrite_in), .Ctl_Branch_in(Ctl_Branch_in),
      .jal_in(jal_in), .jalr_in(jalr_in), .Rd_in(Rd_in), .funct7_in(funct7_in), .funct3_in(funct3_in),
      .PC_in(PC_in), .Rs1_data_in(Rs1_data_in), .Rs2_data_in(Rs2_data_in), .Imm_in(Imm_in),
      .ForwardA_in(ForwardA_in), .ForwardB_in(ForwardB_in), .WB_data_in(WB_data_in),
      .stall_out(stall_out),
      .Ctl_MemtoReg_out(Ctl_MemtoReg_out), .Ctl_RegWrite_out(Ctl_RegWrite_out),
      .Ctl_MemRead_out(Ctl_MemRead_out), .Ctl_MemWrite_out(Ctl_MemWrite_out), .Ctl_Branch_out(Ctl_Branch_out),
      .jal_out(jal_out), .jalr_out(jalr_out), .Zero_out(Zero_out), .Rd_out(Rd_out),
      .funct7_out(funct7_out), .funct3_out(funct3_out), .ALUresult_out(ALUresult_out),
      .Write_Data_out(Write_Data_out), .PCimm_out(PCimm_out), .PC_out(PC_out)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] m_prev   = '0;   // model's view of the current ALUresult_out

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_flags();
      return {24'd0, Ctl_MemtoReg_out, Ctl_RegWrite_out, Ctl_MemRead_out, Ctl_MemWrite_out,
              Ctl_Branch_out, jal_out, jalr_out, Zero_out};
   endfunction

   function automatic logic [31:0] fwd(input logic [1:0] code, input logic [31:0] reg_v);
      if (code == 2'b10) return m_prev;
      if (code == 2'b01) return WB_data_in;
      return reg_v;
   endfunction

   function automatic logic slt(input logic [31:0] a, input logic [31:0] b);
      return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
   endfunction

   function automatic logic [31:0] ref_alu(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3,
                                           input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] imm, input logic jr);
      logic [63:0] ext;
      int          sh;
      sh = int'(b % 32);
      if (jr) return ((a + imm) / 2) * 2;
      if (op == 2'b00) return a + b;
      if (op == 2'b01) return a - b;
      if (op == 2'b10 && f7 == 7'd1) return a + b;
      case (f3)
         3'd0: return (op == 2'b10 && f7[5]) ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return slt(a, b) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: begin
            ext = {{32{a[31]}}, a} >> sh;
            return f7[5] ? ext[31:0] : (a >> sh);
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   function automatic logic ref_zero(input logic [1:0] op, input logic [2:0] f3,
                                     input logic [31:0] a, input logic [31:0] b, input logic j, input logic jr);
      if (j || jr) return 1'b1;
      if (op != 2'b01) return 1'b0;
      case (f3)
         3'd0: return a == b;
         3'd1: return a != b;
         3'd4: return slt(a, b);
         3'd5: return !slt(a, b);
         3'd6: return a < b;
         3'd7: return !(a < b);
         default: return 1'b0;
      endcase
   endfunction

   task automatic drive(input logic [1:0] op, input logic [6:0] f7, input logic [2:0] f3, input logic src,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm,
                        input logic [1:0] fa, input logic [1:0] fb, input logic j, input logic jr);
      Ctl_ALUOp_in = op; funct7_in = f7; funct3_in = f3; Ctl_ALUSrc_in = src;
      Rs1_data_in = rs1; Rs2_data_in = rs2; Imm_in = imm;
      ForwardA_in = fa; ForwardB_in = fb; jal_in = j; jalr_in = jr;
      Ctl_MemtoReg_in = 1'($urandom); Ctl_RegWrite_in = 1'($urandom); Ctl_MemRead_in = 1'($urandom);
      Ctl_MemWrite_in = 1'($urandom); Ctl_Branch_in = 1'($urandom);
      Rd_in = 5'($urandom); PC_in = $urandom & 32'hFFFF_FFFC; WB_data_in = $urandom;
   endtask

   // One non-MUL instruction: predict, clock it through, compare every EX/MEM field.
   task automatic step_normal(input string tag);
      logic [31:0] a, fb, b, e_alu, e_pcimm, e_wd, e_pc, e_flags, e_fn, e_rd;
      logic        e_zero;
      a      = fwd(ForwardA_in, Rs1_data_in);
      fb     = fwd(ForwardB_in, Rs2_data_in);
      b      = Ctl_ALUSrc_in ? Imm_in : fb;
      e_alu  = ref_alu(Ctl_ALUOp_in, funct7_in, funct3_in, a, b, Imm_in, jalr_in);
      e_zero = ref_zero(Ctl_ALUOp_in, funct3_in, a, b, jal_in, jalr_in);
      e_flags = {24'd0, Ctl_MemtoReg_in, Ctl_RegWrite_in, Ctl_MemRead_in, Ctl_MemWrite_in,
                 Ctl_Branch_in, jal_in, jalr_in, e_zero};
      e_fn    = {22'd0, funct7_in, funct3_in};
      e_rd    = {27'd0, Rd_in};
      e_pcimm = PC_in + Imm_in;
      e_wd    = fb;
      e_pc    = PC_in;
      if (flush_in) begin
         e_alu = '0; e_flags = '0; e_fn = '0; e_rd = '0; e_pcimm = '0; e_wd = '0; e_pc = '0;
      end
      #1;
      check({tag, "_stall"}, {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_alu"},   ALUresult_out, e_alu);
      check({tag, "_flags"}, obs_flags(), e_flags);
      check({tag, "_rd"},    {27'd0, Rd_out}, e_rd);
      check({tag, "_fn"},    {22'd0, funct7_out, funct3_out}, e_fn);
      check({tag, "_pcimm"}, PCimm_out, e_pcimm);
      check({tag, "_wdata"}, Write_Data_out, e_wd);
      check({tag, "_pc"},    PC_out, e_pc);
      m_prev = e_alu;
   endtask

   task automatic check_bubble(input string tag);
      check({tag, "_bub_flags"}, obs_flags(), 32'd0);
      check({tag, "_bub_alu"},   ALUresult_out, 32'd0);
   endtask

   // Full MUL: 33 stalled cycles with bubbles, then the product with the MUL's control.
   task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] prod;
      logic [4:0]  rd;
      prod = {32'd0, a} * {32'd0, b};
      drive(2'b10, 7'b0000001, 3'b000, 1'b0, a, b, $urandom, 2'b00, 2'b00, 1'b0, 1'b0);
      Ctl_RegWrite_in = 1'b1;
      rd = Rd_in;
      #1;
      for (int c = 0; c < 33; c++) begin
         check($sformatf("%s_stall%0d", tag, c), {31'd0, stall_out}, 32'd1);
         @(posedge clk); #1;
         check_bubble($sformatf("%s_c%0d", tag, c));
      end
      check({tag, "_done_stall"}, {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      check({tag, "_result"},   ALUresult_out, prod[31:0]);
      check({tag, "_regwrite"}, {31'd0, Ctl_RegWrite_out}, 32'd1);
      check({tag, "_rd"},       {27'd0, Rd_out}, {27'd0, rd});
      m_prev = prod[31:0];
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; flush_in = 1'b0;
      drive(2'b00, 7'd0, 3'd0, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      #12;
      check("rst_stall", {31'd0, stall_out}, 32'd0);
      check("rst_flags", obs_flags(), 32'd0);
      check("rst_alu",   ALUresult_out, 32'd0);
      check("rst_pcimm", PCimm_out, 32'd0);
      reset = 1'b0;
      m_prev = '0;

      // ADD and SUB
      drive(2'b10, 7'h00, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      Ctl_RegWrite_in = 1'b1;
      step_normal("add");
      check("add_const", ALUresult_out, 32'd12);
      check("add_regwrite", {31'd0, Ctl_RegWrite_out}, 32'd1);
      drive(2'b10, 7'h20, 3'd0, 1'b0, 32'd5, 32'd7, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      step_normal("sub");
      check("sub_const", ALUresult_out, 32'hFFFF_FFFE);

      // Branch compares and PC+imm
      drive(2'b01, 7'h00, 3'b100, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0);
      PC_in = 32'h100;
      step_normal("blt");
      check("blt_zero", {31'd0, Zero_out}, 32'd1);
      check("blt_pcimm", PCimm_out, 32'h120);
      drive(2'b01, 7'h00, 3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'h20, 2'b00, 2'b00, 1'b0, 1'b0);
      step_normal("bltu");
      check("bltu_zero", {31'd0, Zero_out}, 32'd0);

      // jalr
      drive(2'b00, 7'h00, 3'd0, 1'b1, 32'h203, 32'd0, 32'h10, 2'b00, 2'b00, 1'b0, 1'b1);
      step_normal("jalr");
      check("jalr_const", ALUresult_out, 32'h212);
      check("jalr_flag", {31'd0, jalr_out}, 32'd1);

      // Forwarding from EX/MEM and from WB
      drive(2'b00, 7'h00, 3'd0, 1'b0, 32'd4, 32'd5, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      step_normal("fwd_pre");
      drive(2'b00, 7'h00, 3'd0, 1'b1, 32'hDEAD_BEEF, 32'd0, 32'd1, 2'b10, 2'b00, 1'b0, 1'b0);
      step_normal("fwd_exmem");
      check("fwd_const", ALUresult_out, 32'd10);
      drive(2'b10, 7'h00, 3'b100, 1'b0, 32'h0F0F_0F0F, 32'h1234_5678, 32'd0, 2'b11, 2'b01, 1'b0, 1'b0);
      step_normal("fwd_wb");

      // Randomized ALU/branch/jump traffic with occasional flushes
      for (int k = 0; k < 40; k++) begin
         logic [1:0] op;
         logic [6:0] f7;
         logic [2:0] f3;
         logic       j, jr;
         op = 2'($urandom);
         f3 = 3'($urandom);
         case ($urandom_range(0, 2))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         if (op == 2'b10 && f7 == 7'h01 && f3 == 3'd0) f7 = 7'h00;
         j = 1'b0; jr = 1'b0;
         case ($urandom_range(0, 5))
            0:       j  = 1'b1;
            1:       jr = 1'b1;
            default: ;
         endcase
         drive(op, f7, f3, 1'($urandom), $urandom, $urandom, $urandom, 2'($urandom), 2'($urandom), j, jr);
         flush_in = ($urandom_range(0, 7) == 0);
         step_normal($sformatf("rnd%0d", k));
         flush_in = 1'b0;
      end

      // Multi-cycle MUL
      run_mul("mul1", 32'h1234_5678, 32'h9);
      check("mul1_const", ALUresult_out, 32'hA3D7_0A38);

      // Flush during BUSY cycle 10, then a normal ADD
      drive(2'b10, 7'b0000001, 3'b000, 1'b0, 32'd1234, 32'd5678, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      @(posedge clk); #1;
      repeat (9) @(posedge clk);
      #1;
      check("flush_pre_stall", {31'd0, stall_out}, 32'd1);
      flush_in = 1'b1;
      #1;
      check("flush_stall", {31'd0, stall_out}, 32'd0);
      @(posedge clk); #1;
      check_bubble("flush");
      flush_in = 1'b0;
      m_prev = '0;
      drive(2'b10, 7'h00, 3'd0, 1'b0, 32'd100, 32'd23, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      Ctl_RegWrite_in = 1'b1;
      step_normal("post_flush_add");
      check("post_flush_const", ALUresult_out, 32'd123);

      // Asynchronous reset in the middle of a MUL
      drive(2'b10, 7'b0000001, 3'b000, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 2'b00, 2'b00, 1'b0, 1'b0);
      repeat (12) @(posedge clk);
      #3;
      check("midmul_stall", {31'd0, stall_out}, 32'd1);
      reset = 1'b1;
      #1;
      check("arst_stall", {31'd0, stall_out}, 32'd0);
      check("arst_flags", obs_flags(), 32'd0);
      check("arst_alu",   ALUresult_out, 32'd0);
      check("arst_rd",    {27'd0, Rd_out}, 32'd0);
      check("arst_pc",    PC_out, 32'd0);
      @(posedge clk); #3;
      reset = 1'b0;
      m_prev = '0;
      run_mul("mul_ff", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      check("mul_ff_const", ALUresult_out, 32'd1);

      // Back-to-back normal op after a MUL, forwarding the product
      drive(2'b00, 7'h00, 3'd0, 1'b1, 32'd0, 32'd0, 32'd41, 2'b10, 2'b00, 1'b0, 1'b0);
      step_normal("after_mul_fwd");
      check("after_mul_const", ALUresult_out, 32'd42);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage RISC-V core, directly upstream of the MEM stage; owns the EX/MEM pipeline register and drives every MEM-stage input.
- Computes ALU result, branch condition (Zero), branch/jump target (PCimm), store data, and operand forwarding.
- Adds an iterative multi-cycle MUL (RV32M, low 32 bits) that stalls the front end while it runs.

Parameters:
- MUL_BITS, 1: multiplier bits retired per BUSY cycle; legal values 1, 2, 4, 8; MUL_N = 32/MUL_BITS BUSY cycles.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush_in  in  1  MEM-stage PCSrc; instruction now in EX is wrong-path
- Ctl_ALUSrc_in  in  1  operand B: 1=imm, 0=forwarded rs2
- Ctl_ALUOp_in  in  2  00 add, 01 branch compare, 10 R-type, 11 I-type ALU
- Ctl_MemtoReg_in / Ctl_RegWrite_in / Ctl_MemRead_in / Ctl_MemWrite_in / Ctl_Branch_in  in  1 each  ID/EX control
- jal_in, jalr_in  in  1 each  jump flags
- Rd_in  in  5  destination register
- funct7_in  in  7; funct3_in  in  3  instruction fields
- PC_in, Rs1_data_in, Rs2_data_in, Imm_in  in  32 each  ID/EX data
- ForwardA_in, ForwardB_in  in  2 each  00 regfile, 10 EX/MEM ALUresult_out, 01 WB_data_in
- WB_data_in  in  32  writeback-stage result
- stall_out  out  1  hold PC/IF/ID/ID-EX
- Ctl_MemtoReg_out / Ctl_RegWrite_out / Ctl_MemRead_out / Ctl_MemWrite_out / Ctl_Branch_out  out  1 each  registered
- jal_out, jalr_out, Zero_out  out  1 each  registered
- Rd_out  out  5; funct7_out  out  7; funct3_out  out  3  registered
- ALUresult_out, Write_Data_out, PCimm_out, PC_out  out  32 each  registered

Behaviour:
- Reset (async): all registered outputs 0, FSM IDLE, stall_out 0.
- Operand A = mux(ForwardA) of Rs1_data_in / ALUresult_out / WB_data_in. Operand fB = same mux on Rs2. B = ALUSrc ? Imm_in : fB. Forward code 11 treated as 00.
- ALUOp 00: A+B. jalr: (A+Imm)&~1.
- ALUOp 10/11 by funct3: 000 ADD, or SUB if funct7[5] and ALUOp=10; 001 SLL; 010 SLT signed; 011 SLTU; 100 XOR; 101 SRL, or SRA if funct7[5]; 110 OR; 111 AND.
- Shift amount B[4:0]; arithmetic mod 2^32.
- ALUOp 01: ALUresult = A-B. Zero = condition true by funct3: BEQ, BNE, BLT, BGE, BLTU, BGEU. jal/jalr force Zero=1.
- PCimm = PC_in + Imm_in (wrap mod 2^32). Write_Data = fB. PC_out = PC_in.
- Normal cycle: EX/MEM register loads all computed values and control each edge; latency 1.
- Bubble: all Ctl_*_out, jal_out, jalr_out, Zero_out = 0; data outputs don't-care, but driven 0.
- MUL: ALUOp=10, funct7=0000001, funct3=000. Other funct3 with funct7=0000001 is undefined; executed as ADD.
- MUL FSM IDLE:
  - MUL present: stall_out=1 combinationally.
  - At edge: latch A, B into multiplicand/multiplier, clear acc, cnt=0, go BUSY, EX/MEM loads bubble.
- MUL FSM BUSY:
  - stall_out=1.
  - Each edge adds MUL_BITS partial products; cnt++.
  - After MUL_N iterations go DONE.
  - EX/MEM loads bubble every BUSY edge.
- MUL FSM DONE:
  - stall_out=0; EX/MEM loads acc[31:0] as ALUresult plus the held instruction's control and Rd; next state IDLE.
  - MUL ID/EX stays stable because it is held by stall.
- Stall length for MUL = MUL_N+1 cycles; result visible after edge MUL_N+2 from the issue cycle.
- flush_in: highest priority over MUL and normal operation.
  - EX/MEM loads bubble, FSM→IDLE, and any in-flight MUL is aborted.
  - stall_out=0 in the flush cycle.
- Async reset mid-MUL: abort immediately; no state survives.
- Forwarding from ALUresult_out during the MUL DONE cycle uses the pre-load value (standard register semantics).

Test Plan:
- ADD: Rs1=5, Rs2=7, ALUOp=10, funct3=0 → next edge ALUresult_out=12, RegWrite_out=1. SUB with funct7=0100000 → 0xFFFFFFFE.
- Branch: BLT with A=0xFFFFFFFF, B=1 → Zero_out=1. BLTU with the same operands → Zero_out=0. PC=0x100, Imm=0x20 → PCimm_out=0x120.
- jalr: Rs1=0x203, Imm=0x10 → ALUresult_out=0x212, jalr_out=1. Forwarding: ForwardA=10 with prior ALUresult_out=9, Imm=1, ALUSrc=1 → ALUresult_out=10.
- MUL (MUL_BITS=1): 0x12345678 × 0x9 → stall_out high 33 cycles, bubbles out each of those cycles, then ALUresult_out=0xA3D70A38. Also check 0xFFFFFFFF × 0xFFFFFFFF → 1.
- flush_in pulsed in BUSY cycle 10 → EX/MEM bubble, stall_out=0 same cycle, FSM IDLE. Then a new ADD completes normally next edge.
- Async reset asserted mid-MUL between edges → all outputs 0 immediately, stall_out=0.
